// File: rtl/i_fetch_responder.sv
// i_fetch_responder: direct-mapped instruction cache responder.
// Synchronous-read arrays, one outstanding line refill at a time.
module i_fetch_responder #(
   parameter int ADDR_WIDTH = 26,
   parameter int DATA_WIDTH = 32,
   parameter int LINES      = 16,
   parameter int LINE_WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] i_pc_next,
   input  logic [ADDR_WIDTH-1:0] i_pc_current,
   output logic [DATA_WIDTH-1:0] o_inst,
   output logic                  o_valid,
   output logic                  o_miss,
   output logic                  o_mem_req_valid,
   input  logic                  i_mem_req_ready,
   output logic [ADDR_WIDTH-1:0] o_mem_req_addr,
   input  logic                  i_mem_rsp_valid,
   input  logic [DATA_WIDTH-1:0] i_mem_rsp_data
);

   localparam int WW  = $clog2(LINE_WORDS);
   localparam int IW  = $clog2(LINES);
   localparam int OFF = WW + 2;
   localparam int HW  = ADDR_WIDTH - OFF;
   localparam int TW  = HW - IW;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      REFILL,
      RELOAD
   } state_t;

   state_t                state;
   logic [WW-1:0]         cnt;
   logic [HW-1:0]         lat_hi;
   logic [LINES-1:0]      valid_bits;
   logic                  valid_q;
   logic [TW-1:0]         tag_q;
   logic [DATA_WIDTH-1:0] line_q [LINE_WORDS];

   logic [DATA_WIDTH-1:0] data_mem [LINES*LINE_WORDS];
   logic [TW-1:0]         tag_mem  [LINES];

   logic [IW-1:0] lat_idx;
   logic [TW-1:0] lat_tag;
   logic [IW-1:0] rd_idx;
   logic [TW-1:0] cur_tag;
   logic [WW-1:0] cur_word;
   logic          hit;
   logic          last;
   logic          wr_en;
   logic          unused_bits;

   assign lat_idx  = lat_hi[IW-1:0];
   assign lat_tag  = lat_hi[HW-1:IW];
   assign rd_idx   = (state == RELOAD) ? lat_idx
                                       : i_pc_next[OFF+:IW];
   assign cur_tag  = i_pc_current[OFF+IW+:TW];
   assign cur_word = i_pc_current[2+:WW];
   assign hit      = valid_q && (tag_q == cur_tag);
   assign last     = (cnt == WW'(LINE_WORDS - 1));
   assign wr_en    = (state == REFILL) && i_mem_rsp_valid;

   assign unused_bits = ^{i_pc_next[1:0],
                          i_pc_next[OFF-1:2],
                          i_pc_next[ADDR_WIDTH-1:OFF+IW],
                          i_pc_current[1:0]};

   // Hit only counts while idle; every other state stalls fetch.
   always_comb begin
      o_valid = (state == IDLE) && hit;
      o_miss  = !o_valid;
      o_inst  = o_valid ? line_q[cur_word] : '0;
   end

   assign o_mem_req_valid = (state == REQ);
   assign o_mem_req_addr  = {lat_hi, {OFF{1'b0}}};

   // Array storage: refill writes, synchronous line/tag read.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         data_mem[{lat_idx, cnt}] <= i_mem_rsp_data;
         if (last) begin
            tag_mem[lat_idx] <= lat_tag;
         end
      end
      tag_q <= tag_mem[rd_idx];
      for (int w = 0; w < LINE_WORDS; w++) begin
         line_q[w] <= data_mem[{rd_idx, WW'(w)}];
      end
   end

   // Control FSM, valid bits and registered valid read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         lat_hi     <= '0;
         valid_bits <= '0;
         valid_q    <= 1'b0;
      end else begin
         valid_q <= valid_bits[rd_idx];
         unique case (state)
            IDLE: begin
               if (!hit) begin
                  state  <= REQ;
                  lat_hi <= i_pc_current[ADDR_WIDTH-1:OFF];
               end
            end
            REQ: begin
               if (i_mem_req_ready) begin
                  state <= REFILL;
                  cnt   <= '0;
               end
            end
            REFILL: begin
               if (i_mem_rsp_valid) begin
                  cnt <= cnt + WW'(1);
                  if (last) begin
                     valid_bits[lat_idx] <= 1'b1;
                     state               <= RELOAD;
                  end
               end
            end
            RELOAD: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i_fetch_responder.sv
// tb_i_fetch_responder: randomized fetch/memory traffic against a
// line-level cache model, plus directed fill/evict/reset scenarios.
module tb_i_fetch_responder;

   localparam int AW = 26;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] pc_next = '0;
   logic [AW-1:0] pc_cur = '0;
   logic [DW-1:0] inst;
   logic          valid;
   logic          miss;
   logic          reqv;
   logic          ready = 1'b0;
   logic [AW-1:0] reqa;
   logic          rspv = 1'b0;
   logic [DW-1:0] rspd = '0;

   int total = 0;
   int bad = 0;
   bit auto_pc = 1'b0;

   always #5 clk = ~clk;

   i_fetch_responder dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_pc_next       (pc_next),
      .i_pc_current    (pc_cur),
      .o_inst          (inst),
      .o_valid         (valid),
      .o_miss          (miss),
      .o_mem_req_valid (reqv),
      .i_mem_req_ready (ready),
      .o_mem_req_addr  (reqa),
      .i_mem_rsp_valid (rspv),
      .i_mem_rsp_data  (rspd)
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Backing memory contents; line 0 holds 0xA0..0xA3.
   function automatic logic [DW-1:0] memw(input logic [AW-1:0] a);
      logic [31:0] w;
      if (a[AW-1:4] == '0) return 32'hA0 + 32'(a[3:2]);
      w = 32'({a[AW-1:2], 2'b00});
      return (w * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   function automatic logic [AW-1:0] rand_pc();
      logic [17:0] t;
      t = 18'($urandom_range(0, 3)) | (18'($urandom_range(0, 1)) << 17);
      return {t, 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3))};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      pc_cur = pc_next;
      #1;
      if (auto_pc) pc_next = miss ? pc_cur : rand_pc();
   endtask

   // Line-level model: what is cached, and whether a fill is in flight.
   bit          m_p [16];
   logic [17:0] m_t [16];
   logic [31:0] m_d [16][4];
   int          m_phase = 0;
   int          m_nb = 0;
   logic [AW-1:0] m_line = '0;
   logic [3:0]  m_idx;
   bit          m_hit;
   bit          m_em;

   // Compare process: check outputs mid-cycle, then advance the model.
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         chk("rst_valid", valid, 0);
         chk("rst_reqv", reqv, 0);
         chk("rst_inst", inst, 0);
         for (int i = 0; i < 16; i++) m_p[i] = 1'b0;
         m_phase = 0;
         m_nb = 0;
      end else begin
         m_idx = pc_cur[7:4];
         m_hit = m_p[m_idx] && (m_t[m_idx] == pc_cur[25:8]);
         m_em  = (m_phase != 0) || !m_hit;
         chk("miss", miss, m_em);
         chk("valid", valid, !m_em);
         chk("reqv", reqv, m_phase == 1);
         if (!m_em) chk("inst", inst, m_d[m_idx][pc_cur[3:2]]);
         if (m_phase == 1) chk("req_addr", reqa, m_line);
         case (m_phase)
            0: if (m_em) begin
               m_phase = 1;
               m_line = {pc_cur[AW-1:4], 4'h0};
            end
            1: if (ready) begin
               m_phase = 2;
               m_nb = 0;
            end
            2: if (rspv) begin
               m_d[m_line[7:4]][m_nb] = rspd;
               m_nb++;
               if (m_nb == 4) begin
                  m_p[m_line[7:4]] = 1'b1;
                  m_t[m_line[7:4]] = m_line[25:8];
                  m_phase = 3;
               end
            end
            default: m_phase = 0;
         endcase
      end
   end

   task automatic fill();
      logic [AW-1:0] ln;
      int n;
      int k;
      ready = 1'b1;
      for (k = 0; k < 10 && !reqv; k++) tick();
      if (!reqv) begin
         chk("fill_req_timeout", 0, 1);
         ready = 1'b0;
         return;
      end
      ln = reqa;
      tick();
      ready = 1'b0;
      n = 0;
      for (k = 0; k < 40 && n < 4; k++) begin
         rspv = 1'b1;
         rspd = memw(ln + 26'(4 * n));
         tick();
         n++;
      end
      rspv = 1'b0;
      tick();
   endtask

   bit          hs;
   bit          tk;
   bit          act;
   int          en;
   logic [AW-1:0] eline;
   logic [AW-1:0] nl;
   logic [5:0]  pat;
   int          kb;

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("post_rst_miss", miss, 1);
      chk("post_rst_valid", valid, 0);
      chk("post_rst_inst", inst, 0);

      tick();
      chk("req0_valid", reqv, 1);
      chk("req0_addr", reqa, 26'h0);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      for (int b = 0; b < 4; b++) begin
         rspv = 1'b1;
         rspd = memw(26'(4 * b));
         tick();
      end
      rspv = 1'b0;
      chk("reload_miss", miss, 1);
      tick();
      chk("hit0_valid", valid, 1);
      chk("hit0_inst", inst, 32'hA0);
      pc_next = 26'h4;
      tick();
      chk("hit4_inst", inst, 32'hA1);
      chk("hit4_miss", miss, 0);

      pc_next = 26'h100;
      tick();
      chk("conflict_miss", miss, 1);
      tick();
      ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("stall_reqv", reqv, 1);
         chk("stall_addr", reqa, 26'h100);
         tick();
      end
      chk("stall_reqv4", reqv, 1);
      chk("stall_addr4", reqa, 26'h100);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      chk("refill_noreq", reqv, 0);
      pat = 6'b110101;
      kb = 0;
      for (int i = 0; i < 6; i++) begin
         rspv = pat[i];
         rspd = rspv ? memw(26'h100 + 26'(4 * kb)) : (32'hBAD0_0000 | i);
         tick();
         if (pat[i]) kb++;
      end
      rspv = 1'b0;
      chk("gap_reload_miss", miss, 1);
      tick();
      chk("gap_hit", inst, memw(26'h100));
      pc_next = 26'h10C;
      tick();
      chk("gap_hit_w3", inst, memw(26'h10C));
      pc_next = 26'h0;
      tick();
      chk("evicted_miss", miss, 1);
      fill();
      chk("refetch0_valid", valid, 1);
      chk("refetch0_inst", inst, 32'hA0);

      pc_next = 26'h40;
      tick();
      tick();
      ready = 1'b1;
      tick();
      ready = 1'b0;
      rspv = 1'b1;
      rspd = memw(26'h40);
      tick();
      rspd = memw(26'h44);
      tick();
      rst_n = 1'b0;
      #1;
      chk("midfill_rst_reqv", reqv, 0);
      chk("midfill_rst_valid", valid, 0);
      chk("midfill_rst_inst", inst, 0);
      rspd = 32'hDEAD_0002;
      tick();
      rspd = 32'hDEAD_0003;
      tick();
      rst_n = 1'b1;
      rspd = 32'hDEAD_0004;
      tick();
      rspd = 32'hDEAD_0005;
      tick();
      rspv = 1'b0;
      chk("refetch40_reqv", reqv, 1);
      chk("refetch40_addr", reqa, 26'h40);
      fill();
      chk("hit40", inst, memw(26'h40));
      pc_next = 26'h48;
      tick();
      chk("hit48", inst, memw(26'h48));

      rspv = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rspd = $urandom;
         pc_next = 26'h40 + 26'(4 * i);
         tick();
         chk("idle_rsp_valid", valid, 1);
         chk("idle_rsp_inst", inst, memw(pc_cur));
      end
      rspv = 1'b0;

      auto_pc = 1'b1;
      act = 1'b0;
      en = 0;
      eline = '0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 299) == 0) begin
            rst_n = 1'b0;
            rspv = 1'b0;
            ready = 1'b0;
            act = 1'b0;
            tick();
            tick();
            rst_n = 1'b1;
         end else begin
            ready = ($urandom_range(0, 2) != 0);
            if (act) begin
               rspv = ($urandom_range(0, 2) != 0);
               rspd = memw(eline + 26'(4 * en));
            end else begin
               rspv = ($urandom_range(0, 3) == 0);
               rspd = $urandom;
            end
            #1;
            hs = reqv && ready;
            tk = act && rspv;
            nl = reqa;
            tick();
            if (hs) begin
               act = 1'b1;
               eline = nl;
               en = 0;
            end
            if (tk) begin
               en++;
               if (en == 4) act = 1'b0;
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
